rob_rename_writer: RTL and testbench

- Write side of the operand-source protocol.
- Owns the architectural register file, the per-register busy/tag rename status, and a 15-entry reorder buffer.
- Allocates ROB tags at dispatch, captures CDB results into ROB entries, and retires in order into the register file.
- Exposes the {busy,value}, {done,value} and tag words that the source-read logic consumes.

---
 rtl/rob_rename_writer_pkg.sv | 31 +++
 rtl/rob_rename_writer_if.sv | 38 +++
 rtl/rob_rename_writer_rename_status_table.sv | 74 +++++++
 rtl/rob_rename_writer.sv | 115 +++++++++++
 tb/tb_rob_rename_writer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_rename_writer_pkg.sv
// Shared types and constants for the ROB / rename write side.
// Tag 0 means "no tag"; tags 1..15 are usable and wrap 15 -> 1.
package rob_rename_writer_pkg;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned REG_ADDR_W  = 3;
   localparam int unsigned TAG_W       = 4;
   localparam int unsigned NUM_REGS    = 2 ** REG_ADDR_W;
   localparam int unsigned ROB_ENTRIES = 2 ** TAG_W - 1;
   localparam int unsigned ROB_SLOTS   = 2 ** TAG_W;

   typedef logic [DATA_W-1:0]     data_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [TAG_W-1:0]      tag_t;

   localparam tag_t TAG_NONE  = TAG_W'(0);
   localparam tag_t TAG_FIRST = TAG_W'(1);
   localparam tag_t TAG_LAST  = TAG_W'(ROB_ENTRIES);

   typedef struct packed {
      logic      valid;
      logic      done;
      reg_addr_t rd;
      data_t     data;
   } rob_entry_t;

   function automatic tag_t next_tag(tag_t t);
      return (t == TAG_LAST) ? TAG_FIRST : t + 1'b1;
   endfunction

endpackage

// File: rtl/rob_rename_writer_if.sv
// Dispatch / CDB / source-lookup / commit bundle between the pipeline and the ROB writer.
interface rob_rename_writer_if;
   import rob_rename_writer_pkg::*;

   logic             disp_valid;
   reg_addr_t        disp_rd;
   logic             disp_ready;
   tag_t             disp_tag;
   logic             cdb_valid;
   tag_t             cdb_tag;
   data_t            cdb_data;
   logic             flush;
   reg_addr_t        src_addr_a;
   reg_addr_t        src_addr_b;
   logic [DATA_W:0]  src_reg_a;
   logic [DATA_W:0]  src_reg_b;
   logic [DATA_W:0]  src_rob_a;
   logic [DATA_W:0]  src_rob_b;
   tag_t             src_tag_a;
   tag_t             src_tag_b;
   logic             commit_valid;
   reg_addr_t        commit_rd;
   data_t            commit_data;
   tag_t             rob_count;

   modport master (
      output disp_valid, disp_rd, cdb_valid, cdb_tag, cdb_data, flush, src_addr_a, src_addr_b,
      input  disp_ready, disp_tag, src_reg_a, src_reg_b, src_rob_a, src_rob_b, src_tag_a,
             src_tag_b, commit_valid, commit_rd, commit_data, rob_count
   );

   modport slave (
      input  disp_valid, disp_rd, cdb_valid, cdb_tag, cdb_data, flush, src_addr_a, src_addr_b,
      output disp_ready, disp_tag, src_reg_a, src_reg_b, src_rob_a, src_rob_b, src_tag_a,
             src_tag_b, commit_valid, commit_rd, commit_data, rob_count
   );

endinterface

// File: rtl/rob_rename_writer_rename_status_table.sv
// Architectural register file plus per-register busy/tag rename status,
// with two combinational read ports.
module rob_rename_writer_rename_status_table
   import rob_rename_writer_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush_i,
   input  logic      disp_en_i,
   input  reg_addr_t disp_rd_i,
   input  tag_t      disp_tag_i,
   input  logic      commit_en_i,
   input  reg_addr_t commit_rd_i,
   input  tag_t      commit_tag_i,
   input  data_t     commit_data_i,
   input  reg_addr_t rd_addr_a_i,
   input  reg_addr_t rd_addr_b_i,
   output logic      busy_a_o,
   output logic      busy_b_o,
   output data_t     value_a_o,
   output data_t     value_b_o,
   output tag_t      tag_a_o,
   output tag_t      tag_b_o
);

   data_t               regs_q [NUM_REGS];
   data_t               regs_d [NUM_REGS];
   tag_t                tags_q [NUM_REGS];
   tag_t                tags_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   always_comb begin
      regs_d = regs_q;
      tags_d = tags_q;
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = '0;
         for (int i = 0; i < NUM_REGS; i++) tags_d[i] = TAG_NONE;
      end else begin
         if (commit_en_i) begin
            regs_d[commit_rd_i] = commit_data_i;
            if (tags_q[commit_rd_i] == commit_tag_i) busy_d[commit_rd_i] = 1'b0;
         end
         // Applied after the commit clear so a same-cycle rename of rd keeps it busy.
         if (disp_en_i) begin
            busy_d[disp_rd_i] = 1'b1;
            tags_d[disp_rd_i] = disp_tag_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
            tags_q[i] <= TAG_NONE;
         end
      end else begin
         busy_q <= busy_d;
         regs_q <= regs_d;
         tags_q <= tags_d;
      end
   end

   assign busy_a_o  = busy_q[rd_addr_a_i];
   assign busy_b_o  = busy_q[rd_addr_b_i];
   assign value_a_o = regs_q[rd_addr_a_i];
   assign value_b_o = regs_q[rd_addr_b_i];
   assign tag_a_o   = busy_q[rd_addr_a_i] ? tags_q[rd_addr_a_i] : TAG_NONE;
   assign tag_b_o   = busy_q[rd_addr_b_i] ? tags_q[rd_addr_b_i] : TAG_NONE;

endmodule

// File: rtl/rob_rename_writer.sv
// Reorder buffer write side: tag allocation at dispatch, CDB capture, in-order
// retirement into the register file, and operand-source lookup words.
module rob_rename_writer
   import rob_rename_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   rob_rename_writer_if.slave bus_io
);

   rob_entry_t rob_q [ROB_SLOTS];
   rob_entry_t rob_d [ROB_SLOTS];
   tag_t       head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic       commit_valid_q;
   reg_addr_t  commit_rd_q;
   data_t      commit_data_q;
   rob_entry_t head_entry, cdb_entry;
   logic       disp_ready, do_disp, do_commit, cdb_hit;
   logic       busy_a, busy_b;
   data_t      value_a, value_b;
   tag_t       tag_a, tag_b;

   assign head_entry = rob_q[head_q];
   assign cdb_entry  = rob_q[bus_io.cdb_tag];
   assign disp_ready = (count_q != TAG_LAST);
   assign do_disp    = bus_io.disp_valid & disp_ready & ~bus_io.flush;
   assign do_commit  = head_entry.valid & head_entry.done & ~bus_io.flush;
   assign cdb_hit    = bus_io.cdb_valid & ~bus_io.flush & (bus_io.cdb_tag != TAG_NONE) &
                       cdb_entry.valid & ~cdb_entry.done;

   always_comb begin
      rob_d   = rob_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus_io.flush) begin
         for (int i = 0; i < ROB_SLOTS; i++) rob_d[i] = '0;
         head_d  = TAG_FIRST;
         tail_d  = TAG_FIRST;
         count_d = '0;
      end else begin
         if (cdb_hit) begin
            rob_d[bus_io.cdb_tag].done = 1'b1;
            rob_d[bus_io.cdb_tag].data = bus_io.cdb_data;
         end
         if (do_commit) begin
            rob_d[head_q] = '0;
            head_d        = next_tag(head_q);
         end
         if (do_disp) begin
            rob_d[tail_q] = '{valid: 1'b1, done: 1'b0, rd: bus_io.disp_rd, data: '0};
            tail_d        = next_tag(tail_q);
         end
         count_d = count_q + tag_t'(do_disp) - tag_t'(do_commit);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROB_SLOTS; i++) rob_q[i] <= '0;
         head_q         <= TAG_FIRST;
         tail_q         <= TAG_FIRST;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_data_q  <= '0;
      end else begin
         rob_q          <= rob_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= do_commit;
         if (do_commit) begin
            commit_rd_q   <= head_entry.rd;
            commit_data_q <= head_entry.data;
         end
      end
   end

   rob_rename_writer_rename_status_table u_rst (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (bus_io.flush),
      .disp_en_i     (do_disp),
      .disp_rd_i     (bus_io.disp_rd),
      .disp_tag_i    (tail_q),
      .commit_en_i   (do_commit),
      .commit_rd_i   (head_entry.rd),
      .commit_tag_i  (head_q),
      .commit_data_i (head_entry.data),
      .rd_addr_a_i   (bus_io.src_addr_a),
      .rd_addr_b_i   (bus_io.src_addr_b),
      .busy_a_o      (busy_a),
      .busy_b_o      (busy_b),
      .value_a_o     (value_a),
      .value_b_o     (value_b),
      .tag_a_o       (tag_a),
      .tag_b_o       (tag_b)
   );

   assign bus_io.disp_ready   = disp_ready;
   assign bus_io.disp_tag     = tail_q;
   assign bus_io.rob_count    = count_q;
   assign bus_io.commit_valid = commit_valid_q;
   assign bus_io.commit_rd    = commit_rd_q;
   assign bus_io.commit_data  = commit_data_q;
   assign bus_io.src_reg_a    = {busy_a, value_a};
   assign bus_io.src_reg_b    = {busy_b, value_b};
   assign bus_io.src_tag_a    = tag_a;
   assign bus_io.src_tag_b    = tag_b;
   // Tag is already masked to 0 when not busy; the busy gate keeps entry 0 out of the result.
   assign bus_io.src_rob_a    = busy_a ? {rob_q[tag_a].done, rob_q[tag_a].data} : '0;
   assign bus_io.src_rob_b    = busy_b ? {rob_q[tag_b].done, rob_q[tag_b].data} : '0;

endmodule

// File: tb/tb_rob_rename_writer.sv
// Directed bench for rob_rename_writer: dispatch, CDB, commit, full/wrap, rename
// priority, flush and asynchronous reset.
module tb_rob_rename_writer;
   import rob_rename_writer_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   rob_rename_writer_if bus ();

   rob_rename_writer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input logic [2:0] rd);
      bus.disp_valid = 1'b1;
      bus.disp_rd    = rd;
      step();
      bus.disp_valid = 1'b0;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [15:0] data);
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = tag;
      bus.cdb_data  = data;
      step();
      bus.cdb_valid = 1'b0;
   endtask

   task automatic do_reset();
      bus.disp_valid = 1'b0;
      bus.disp_rd    = '0;
      bus.cdb_valid  = 1'b0;
      bus.cdb_tag    = '0;
      bus.cdb_data   = '0;
      bus.flush      = 1'b0;
      rst_n          = 1'b0;
      step();
      rst_n          = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      bus.src_addr_a = 3'd3;
      #1;
      n_cmp++; if (bus.src_reg_a !== 17'h0) begin n_fail++;
         $display("FAIL reset_src_reg: got %h want %h", bus.src_reg_a, 17'h0); end
      n_cmp++; if (bus.src_tag_a !== 4'd0) begin n_fail++;
         $display("FAIL reset_src_tag: got %0d want 0", bus.src_tag_a); end
      n_cmp++; if (bus.disp_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_disp_ready: got %b want 1", bus.disp_ready); end
      n_cmp++; if (bus.rob_count !== 4'd0) begin n_fail++;
         $display("FAIL reset_count: got %0d want 0", bus.rob_count); end
      n_cmp++; if (bus.disp_tag !== 4'd1) begin n_fail++;
         $display("FAIL reset_disp_tag: got %0d want 1", bus.disp_tag); end
      n_cmp++; if (bus.commit_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_commit_valid: got %b want 0", bus.commit_valid); end
   endtask

   task automatic test_basic();
      do_reset();
      bus.src_addr_a = 3'd2;
      dispatch(3'd2);
      n_cmp++; if (bus.src_reg_a !== 17'h10000) begin n_fail++;
         $display("FAIL basic_busy: got %h want %h", bus.src_reg_a, 17'h10000); end
      n_cmp++; if (bus.src_tag_a !== 4'd1) begin n_fail++;
         $display("FAIL basic_tag: got %0d want 1", bus.src_tag_a); end
      n_cmp++; if (bus.disp_tag !== 4'd2 || bus.rob_count !== 4'd1) begin n_fail++;
         $display("FAIL basic_tail: got tag %0d count %0d want 2/1", bus.disp_tag, bus.rob_count); end
      cdb(4'd1, 16'h1234);
      n_cmp++; if (bus.src_rob_a !== 17'h11234) begin n_fail++;
         $display("FAIL basic_src_rob: got %h want %h", bus.src_rob_a, 17'h11234); end
      n_cmp++; if (bus.commit_valid !== 1'b0) begin n_fail++;
         $display("FAIL basic_no_early_commit: got %b want 0", bus.commit_valid); end
      step();
      n_cmp++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 3'd2) begin n_fail++;
         $display("FAIL basic_commit: got v%b rd%0d want v1 rd2", bus.commit_valid, bus.commit_rd); end
      n_cmp++; if (bus.commit_data !== 16'h1234) begin n_fail++;
         $display("FAIL basic_commit_data: got %h want 1234", bus.commit_data); end
      n_cmp++; if (bus.src_reg_a !== 17'h01234 || bus.src_tag_a !== 4'd0) begin n_fail++;
         $display("FAIL basic_retired: got %h/%0d want 01234/0", bus.src_reg_a, bus.src_tag_a); end
      step();
      n_cmp++; if (bus.commit_valid !== 1'b0) begin n_fail++;
         $display("FAIL basic_pulse_end: got %b want 0", bus.commit_valid); end
   endtask

   task automatic test_full_wrap();
      logic [3:0] i4;
      do_reset();
      for (int i = 1; i <= 15; i++) begin
         i4 = 4'(i);
         dispatch(i4[2:0]);
      end
      n_cmp++; if (bus.disp_ready !== 1'b0 || bus.rob_count !== 4'd15) begin n_fail++;
         $display("FAIL full_state: got rdy%b cnt%0d want 0/15", bus.disp_ready, bus.rob_count); end
      n_cmp++; if (bus.disp_tag !== 4'd1) begin n_fail++;
         $display("FAIL full_tail_wrap: got %0d want 1", bus.disp_tag); end
      bus.src_addr_a = 3'd3;
      dispatch(3'd3);
      n_cmp++; if (bus.rob_count !== 4'd15 || bus.src_tag_a !== 4'd11) begin n_fail++;
         $display("FAIL full_reject: got cnt%0d tag%0d want 15/11", bus.rob_count, bus.src_tag_a); end
      cdb(4'd1, 16'hAAAA);
      bus.disp_valid = 1'b1;
      bus.disp_rd    = 3'd6;
      step();
      bus.disp_valid = 1'b0;
      bus.src_addr_a = 3'd1;
      bus.src_addr_b = 3'd6;
      #1;
      n_cmp++; if (bus.rob_count !== 4'd14 || bus.disp_ready !== 1'b1) begin n_fail++;
         $display("FAIL full_commit_count: got %0d/%b want 14/1", bus.rob_count, bus.disp_ready); end
      n_cmp++; if (bus.commit_valid !== 1'b1 || bus.commit_data !== 16'hAAAA) begin n_fail++;
         $display("FAIL full_commit: got v%b %h want v1 aaaa", bus.commit_valid, bus.commit_data); end
      n_cmp++; if (bus.src_reg_a !== 17'h1AAAA || bus.src_tag_a !== 4'd9) begin n_fail++;
         $display("FAIL full_r1_renamed: got %h/%0d want 1aaaa/9", bus.src_reg_a, bus.src_tag_a); end
      n_cmp++; if (bus.src_tag_b !== 4'd14) begin n_fail++;
         $display("FAIL full_no_bypass: got %0d want 14", bus.src_tag_b); end
      dispatch(3'd6);
      n_cmp++; if (bus.src_tag_b !== 4'd1 || bus.rob_count !== 4'd15) begin n_fail++;
         $display("FAIL wrap_tag: got tag%0d cnt%0d want 1/15", bus.src_tag_b, bus.rob_count); end
      n_cmp++; if (bus.disp_tag !== 4'd2) begin n_fail++;
         $display("FAIL wrap_tail: got %0d want 2", bus.disp_tag); end
   endtask

   task automatic test_double_rename();
      do_reset();
      dispatch(3'd5);
      dispatch(3'd5);
      cdb(4'd1, 16'h0055);
      step();
      bus.src_addr_a = 3'd5;
      #1;
      n_cmp++; if (bus.src_reg_a !== 17'h10055 || bus.src_tag_a !== 4'd2) begin n_fail++;
         $display("FAIL rename_keep_busy: got %h/%0d want 10055/2", bus.src_reg_a, bus.src_tag_a); end
      n_cmp++; if (bus.src_rob_a !== 17'h0 || bus.rob_count !== 4'd1) begin n_fail++;
         $display("FAIL rename_rob: got %h cnt%0d want 0/1", bus.src_rob_a, bus.rob_count); end
      n_cmp++; if (bus.commit_rd !== 3'd5 || bus.commit_valid !== 1'b1) begin n_fail++;
         $display("FAIL rename_commit: got rd%0d v%b want 5/1", bus.commit_rd, bus.commit_valid); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      bus.src_addr_a = 3'd4;
      dispatch(3'd4);
      cdb(4'd1, 16'h4444);
      dispatch(3'd4);
      n_cmp++; if (bus.src_tag_a !== 4'd2 || bus.src_reg_a !== 17'h14444) begin n_fail++;
         $display("FAIL same_rename_wins: got %0d/%h want 2/14444", bus.src_tag_a, bus.src_reg_a); end
      n_cmp++; if (bus.rob_count !== 4'd1 || bus.commit_valid !== 1'b1) begin n_fail++;
         $display("FAIL same_count: got %0d/%b want 1/1", bus.rob_count, bus.commit_valid); end
      n_cmp++; if (bus.disp_tag !== 4'd3) begin n_fail++;
         $display("FAIL same_tail: got %0d want 3", bus.disp_tag); end
      cdb(4'd1, 16'h9999);
      n_cmp++; if (bus.rob_count !== 4'd1 || bus.commit_valid !== 1'b0) begin n_fail++;
         $display("FAIL stale_cdb: got %0d/%b want 1/0", bus.rob_count, bus.commit_valid); end
      n_cmp++; if (bus.src_rob_a !== 17'h0) begin n_fail++;
         $display("FAIL stale_cdb_rob: got %h want 0", bus.src_rob_a); end
   endtask

   task automatic test_dup_cdb();
      do_reset();
      dispatch(3'd6);
      dispatch(3'd7);
      cdb(4'd2, 16'h2222);
      cdb(4'd2, 16'h7777);
      bus.src_addr_b = 3'd7;
      #1;
      n_cmp++; if (bus.src_rob_b !== 17'h12222) begin n_fail++;
         $display("FAIL dup_cdb: got %h want 12222", bus.src_rob_b); end
      cdb(4'd0, 16'h5555);
      n_cmp++; if (bus.rob_count !== 4'd2 || bus.commit_valid !== 1'b0) begin n_fail++;
         $display("FAIL in_order_wait: got %0d/%b want 2/0", bus.rob_count, bus.commit_valid); end
      cdb(4'd1, 16'h1111);
      step();
      n_cmp++; if (bus.commit_data !== 16'h1111 || bus.commit_rd !== 3'd6) begin n_fail++;
         $display("FAIL order_first: got %h rd%0d want 1111/6", bus.commit_data, bus.commit_rd); end
      step();
      n_cmp++; if (bus.commit_data !== 16'h2222 || bus.commit_valid !== 1'b1) begin n_fail++;
         $display("FAIL order_second: got %h v%b want 2222/1", bus.commit_data, bus.commit_valid); end
   endtask

   task automatic test_flush_and_reset();
      do_reset();
      dispatch(3'd1);
      cdb(4'd1, 16'h0101);
      step();
      dispatch(3'd1);
      dispatch(3'd2);
      dispatch(3'd3);
      cdb(4'd2, 16'hBEEF);
      bus.flush      = 1'b1;
      bus.disp_valid = 1'b1;
      bus.disp_rd    = 3'd5;
      bus.cdb_valid  = 1'b1;
      bus.cdb_tag    = 4'd3;
      bus.cdb_data   = 16'h3333;
      step();
      bus.flush      = 1'b0;
      bus.disp_valid = 1'b0;
      bus.cdb_valid  = 1'b0;
      bus.src_addr_a = 3'd1;
      bus.src_addr_b = 3'd2;
      #1;
      n_cmp++; if (bus.rob_count !== 4'd0 || bus.disp_tag !== 4'd1) begin n_fail++;
         $display("FAIL flush_ptrs: got cnt%0d tag%0d want 0/1", bus.rob_count, bus.disp_tag); end
      n_cmp++; if (bus.commit_valid !== 1'b0) begin n_fail++;
         $display("FAIL flush_no_commit: got %b want 0", bus.commit_valid); end
      n_cmp++; if (bus.src_reg_a !== 17'h00101 || bus.src_tag_a !== 4'd0) begin n_fail++;
         $display("FAIL flush_regfile: got %h/%0d want 00101/0", bus.src_reg_a, bus.src_tag_a); end
      n_cmp++; if (bus.src_reg_b !== 17'h0) begin n_fail++;
         $display("FAIL flush_busy_r2: got %h want 0", bus.src_reg_b); end
      bus.src_addr_a = 3'd5;
      #1;
      n_cmp++; if (bus.src_reg_a !== 17'h0) begin n_fail++;
         $display("FAIL flush_disp_suppressed: got %h want 0", bus.src_reg_a); end
      step();
      n_cmp++; if (bus.commit_valid !== 1'b0) begin n_fail++;
         $display("FAIL flush_quiet: got %b want 0", bus.commit_valid); end
      dispatch(3'd2);
      n_cmp++; if (bus.src_tag_b !== 4'd1 || bus.disp_tag !== 4'd2) begin n_fail++;
         $display("FAIL flush_restart: got %0d/%0d want 1/2", bus.src_tag_b, bus.disp_tag); end
      cdb(4'd1, 16'h0A0A);
      step();
      n_cmp++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 3'd2) begin n_fail++;
         $display("FAIL pre_reset_commit: got v%b rd%0d want 1/2", bus.commit_valid, bus.commit_rd); end
      #2;
      rst_n = 1'b0;
      bus.src_addr_a = 3'd1;
      #1;
      n_cmp++; if (bus.commit_valid !== 1'b0 || bus.commit_data !== 16'h0) begin n_fail++;
         $display("FAIL async_commit: got v%b %h want 0/0", bus.commit_valid, bus.commit_data); end
      n_cmp++; if (bus.src_reg_a !== 17'h0 || bus.src_reg_b !== 17'h0) begin n_fail++;
         $display("FAIL async_regfile: got %h/%h want 0/0", bus.src_reg_a, bus.src_reg_b); end
      n_cmp++; if (bus.rob_count !== 4'd0 || bus.disp_tag !== 4'd1) begin n_fail++;
         $display("FAIL async_ptrs: got cnt%0d tag%0d want 0/1", bus.rob_count, bus.disp_tag); end
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      n_cmp          = 0;
      n_fail         = 0;
      rst_n          = 1'b0;
      bus.src_addr_a = '0;
      bus.src_addr_b = '0;
      test_reset();
      test_basic();
      test_full_wrap();
      test_double_rename();
      test_same_cycle();
      test_dup_cdb();
      test_flush_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
